// File: rtl/note_arbiter.sv
// note_arbiter: round-robin scheduler sharing the 4:1 note-decision mux among
// four note sources (0 keyboard, 1 sequencer, 2 replay, 3 test pattern).
// A grant is held for NOTE_TICKS tempo ticks, followed by GAP_TICKS ticks of
// silence, and the served source receives a one-cycle ack.
//
// Optional feature macro: NOTE_ARB_PREEMPT_EN
//   defined   -> source 0 cuts any other playing note (no ack) and is granted
//                next, without disturbing the round-robin pointer
//   undefined -> pure round-robin
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   tick     one-cycle tempo strobe
//   req[3:0] per-source request, held until ack or abandon
//   sel      decision-mux select (current/last grantee)
//   grant    one-hot grant, zero when no note plays
//   note_on  high while a granted note sounds
//   ack      one-cycle completion pulse to the served source
//   busy     high in PLAY and GAP
module note_arbiter #(
  parameter int unsigned NOTE_TICKS = 8,
  parameter int unsigned GAP_TICKS  = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       note_on,
  output logic [3:0] ack,
  output logic       busy
);

`ifdef NOTE_ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_e;

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
  localparam state_e           END_NEXT  = (GAP_TICKS != 0) ? S_GAP : S_IDLE;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       grant_q, grant_d;
  logic             note_on_q, note_on_d;
  logic [3:0]       ack_q, ack_d;
  logic             busy_q, busy_d;
  // Set while a preemptive source-0 note is pending or playing; that note
  // must not move the round-robin pointer.
  logic             pre_q, pre_d;

  logic [1:0]       pick_idx;
  logic             pick_vld;
  logic [1:0]       cand;

  // Round-robin pick: scan last+1 .. last+4; iterating backwards lets the
  // earliest candidate in scan order win.
  always_comb begin
    pick_idx = last_q;
    pick_vld = 1'b0;
    cand     = last_q;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (req[cand]) begin
        pick_idx = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    note_on_d = note_on_q;
    ack_d     = '0;
    pre_d     = pre_q;

    case (state_q)
      S_IDLE: begin
        if (PREEMPT && pre_q && req[0]) begin
          state_d   = S_PLAY;
          grant_d   = 4'b0001;
          sel_d     = 2'd0;
          note_on_d = 1'b1;
          cnt_d     = '0;
        end else begin
          pre_d = 1'b0;
          if (pick_vld) begin
            state_d   = S_PLAY;
            grant_d   = 4'(1) << pick_idx;
            sel_d     = pick_idx;
            note_on_d = 1'b1;
            cnt_d     = '0;
          end
        end
      end

      S_PLAY: begin
        if (!req[sel_q]) begin
          // Abandon wins over a coincident end tick or a preempt.
          state_d   = END_NEXT;
          grant_d   = '0;
          note_on_d = 1'b0;
          cnt_d     = '0;
          last_d    = pre_q ? last_q : sel_q;
          pre_d     = 1'b0;
        end else if (PREEMPT && req[0] && (sel_q != 2'd0)) begin
          state_d   = END_NEXT;
          grant_d   = '0;
          note_on_d = 1'b0;
          cnt_d     = '0;
          pre_d     = 1'b1;
        end else if (tick) begin
          if (cnt_q == NOTE_LAST) begin
            state_d   = END_NEXT;
            grant_d   = '0;
            note_on_d = 1'b0;
            cnt_d     = '0;
            ack_d     = 4'(1) << sel_q;
            last_d    = pre_q ? last_q : sel_q;
            pre_d     = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_GAP: begin
        if (tick) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= 2'd3;
      sel_q     <= 2'd0;
      grant_q   <= '0;
      note_on_q <= 1'b0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      pre_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      note_on_q <= note_on_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      pre_q     <= pre_d;
    end
  end

  assign sel     = sel_q;
  assign grant   = grant_q;
  assign note_on = note_on_q;
  assign ack     = ack_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_note_arbiter.sv
// Testbench for note_arbiter: reset values, a vector table, randomized traffic
// against a transaction-level model, and directed multi-cycle sequences.
module tb_note_arbiter;

  localparam int M_NOTE = 8;
  localparam int M_GAP  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       tick, tick0;
  logic [3:0] req, req0;
  logic [1:0] sel, sel0;
  logic [3:0] grant, grant0, ack, ack0;
  logic       note_on, note_on0, busy, busy0;

  note_arbiter #(.NOTE_TICKS(8), .GAP_TICKS(1), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .req(req),
    .sel(sel), .grant(grant), .note_on(note_on), .ack(ack), .busy(busy)
  );

  note_arbiter #(.NOTE_TICKS(3), .GAP_TICKS(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .tick(tick0), .req(req0),
    .sel(sel0), .grant(grant0), .note_on(note_on0), .ack(ack0), .busy(busy0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: who is playing, ticks played, gap ticks remaining.
  int         m_who, m_played, m_gap_left, m_last, m_sel;
  logic [3:0] m_ack;

  task automatic model_reset();
    m_who = -1; m_played = 0; m_gap_left = 0; m_last = 3; m_sel = 0; m_ack = '0;
  endtask

  task automatic model_end(input bit acked);
    if (acked) m_ack[m_who] = 1'b1;
    m_last     = m_who;
    m_who      = -1;
    m_gap_left = M_GAP;
  endtask

  task automatic model_step(input logic [3:0] r, input logic t);
    m_ack = '0;
    if (m_who >= 0) begin
      if (!r[m_who]) model_end(1'b0);
      else if (t) begin
        m_played++;
        if (m_played == M_NOTE) model_end(1'b1);
      end
    end else if (m_gap_left > 0) begin
      if (t) m_gap_left--;
    end else if (r != 4'b0) begin
      for (int k = 1; k <= 4; k++) begin
        int j;
        j = (m_last + k) % 4;
        if (m_who < 0 && r[j]) m_who = j;
      end
      m_sel    = m_who;
      m_played = 0;
    end
  endtask

  function automatic logic [11:0] model_out();
    logic [3:0] g;
    g = (m_who >= 0) ? (4'b0001 << m_who) : 4'b0000;
    return {g, 2'(m_sel), (m_who >= 0), m_ack, ((m_who >= 0) || (m_gap_left > 0))};
  endfunction

  typedef struct {
    logic [3:0] req;
    logic       tick;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       note_on;
    logic [3:0] ack;
    logic       busy;
  } vec_t;

  vec_t vecs[14];

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0; req0 = '0; tick = 1'b0; tick0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int cyc;
    bit found;
    logic [3:0] exp_order [5];
    logic [3:0] r;

    vecs[0] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b1};
    for (int i = 1; i <= 7; i++)
      vecs[i] = '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b1};
    vecs[8]  = '{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b1};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b1};
    vecs[10] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
    vecs[11] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b1};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b1};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0};

    reset_n = 1'b1;
    req = '0; req0 = '0; tick = 1'b0; tick0 = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_sel", 32'(sel), 32'h0);
    chk("reset_note_on", 32'(note_on), 32'h0);
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Vector table: inputs applied before an edge, outputs checked after it.
    for (int i = 0; i < 14; i++) begin
      req  = vecs[i].req;
      tick = vecs[i].tick;
      @(negedge clk);
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
      chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
      chk($sformatf("vec%0d_note_on", i), 32'(note_on), 32'(vecs[i].note_on));
      chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].ack));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
`ifdef NOTE_ARB_PREEMPT_EN
      r[0] = 1'b0;
`endif
      req  = r;
      tick = 1'($urandom_range(0, 1));
      model_step(req, tick);
      @(negedge clk);
      chk($sformatf("rand%0d", c), 32'({grant, sel, note_on, ack, busy}), 32'(model_out()));
    end

    // All four requesting: strict rotation, eight ticks per note, one ack each.
    do_reset();
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    req = 4'b1111; tick = 1'b1;
    for (int n = 0; n < 5; n++) begin
      found = 1'b0;
      for (int w = 0; w < 40 && !found; w++) begin
        @(negedge clk);
        if (grant != 4'b0) found = 1'b1;
      end
      chk($sformatf("rr%0d_grant_seen", n), 32'(found), 32'h1);
      chk($sformatf("rr%0d_grant", n), 32'(grant), 32'(exp_order[n]));
      found = 1'b0;
      cyc = 0;
      for (int w = 0; w < 40 && !found; w++) begin
        @(negedge clk);
        cyc++;
        if (ack != 4'b0) found = 1'b1;
      end
      chk($sformatf("rr%0d_ack", n), 32'(ack), 32'(exp_order[n]));
      chk($sformatf("rr%0d_len", n), 32'(cyc), 32'd8);
      chk($sformatf("rr%0d_grant_off", n), 32'(grant), 32'h0);
    end

    // Asynchronous reset in the middle of a note.
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    chk("arst_pre_grant", 32'(grant), 32'h4);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_note_on", 32'(note_on), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_sel", 32'(sel), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b0110;
    @(negedge clk);
    chk("arst_after_grant", 32'(grant), 32'h2);
    chk("arst_after_sel", 32'(sel), 32'h1);

    // No-gap instance: ack, one IDLE cycle, next grant.
    do_reset();
    req0 = 4'b0011; tick0 = 1'b1;
    @(negedge clk);
    chk("nogap_grant0", 32'(grant0), 32'h1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("nogap_ack", 32'(ack0), 32'h1);
    chk("nogap_grant_off", 32'(grant0), 32'h0);
    chk("nogap_busy", 32'(busy0), 32'h0);
    @(negedge clk);
    chk("nogap_grant1", 32'(grant0), 32'h2);
    chk("nogap_ack_clear", 32'(ack0), 32'h0);

`ifdef NOTE_ARB_PREEMPT_EN
    // Keyboard preempts source 3; source 3 is served again right after.
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    req = 4'b1110;
    @(negedge clk);
    chk("pre_grant3", 32'(grant), 32'h8);
    req = 4'b1111;
    @(negedge clk);
    chk("pre_cut_grant", 32'(grant), 32'h0);
    chk("pre_cut_ack", 32'(ack), 32'h0);
    tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_grant0", 32'(grant), 32'h1);
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      @(negedge clk);
      if (ack != 4'b0) found = 1'b1;
    end
    chk("pre_ack0", 32'(ack), 32'h1);
    req = 4'b1110;
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      @(negedge clk);
      if (grant != 4'b0) found = 1'b1;
    end
    chk("pre_regrant3", 32'(grant), 32'h8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
